seg_scan_decoder: RTL and testbench

- Receive-side counterpart of the multiplexed 7-segment driver (an/seg) used by the up/down counter top level.
- Samples the scanned anode and segment lines, waits for each digit to settle, and decodes each segment pattern back to a hex nibble.
- Assembles the four nibbles into the 16-bit displayed value.
- Used in self-checking benches and on-board loopback to confirm that the display shows the counter value.

---
 rtl/seg_scan_decoder.sv | 149 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: watches a multiplexed, active-low 7-segment display bus
// (an/seg) and turns it back into the 16-bit hex value being shown. Each
// digit has to stay stable for SETTLE registered samples before it is
// decoded. A frame is reported once all four digits have been seen.
module seg_scan_decoder #(
  parameter int SETTLE = 4,
  parameter int CW     = 8
) (
  input  logic        clkin,
  input  logic        btnR,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  digit_seen,
  output logic        bad_seg,
  output logic        an_err
);

  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  // Turns an active-low gfedcba pattern into {legal, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // Registered input copy (s_*) and the sample that came before it (p_*).
  logic [3:0]    s_an, p_an;
  logic [6:0]    s_seg, p_seg;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          captured, captured_nxt;
  logic [3:0]    slot [4];

  logic          same, cap_base, fire;
  logic [3:0]    an_low;
  logic          one_low, multi_low;
  logic [1:0]    idx;
  logic [4:0]    dec;
  logic          frame_done;
  logic [3:0]    seen_nxt;
  logic          slot_we, bad_nxt, err_nxt;

  // Stability tracking, event classification and next frame-flag state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
    cnt_nxt      = '0;
    cap_base     = 1'b0;
    fire         = 1'b0;
    captured_nxt = 1'b0;
    idx          = 2'd0;
    slot_we      = 1'b0;
    bad_nxt      = 1'b0;
    err_nxt      = 1'b0;

    same = ({s_an, s_seg} == {p_an, p_seg});
    if (!same) begin
      cnt_nxt  = CW'(1);
      cap_base = 1'b0;
    end else begin
      cnt_nxt  = (cnt >= SETTLE_C) ? SETTLE_C : cnt + CW'(1);
      cap_base = captured;
    end
    fire         = (cnt_nxt == SETTLE_C) && !cap_base;
    captured_nxt = cap_base | fire;

    an_low    = ~s_an;
    one_low   = (an_low != 4'b0000) && ((an_low & (an_low - 4'd1)) == 4'b0000);
    multi_low = (an_low != 4'b0000) && !one_low;
    case (an_low)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    dec = decode(s_seg);

    // A full frame is retired first; a capture in the same cycle then
    // lands in the fresh frame.
    frame_done = (digit_seen == 4'b1111);
    seen_nxt   = frame_done ? 4'b0000 : digit_seen;

    if (fire && one_low) begin
      if (dec[4]) begin
        slot_we       = 1'b1;
        seen_nxt[idx] = 1'b1;
      end else begin
        bad_nxt       = 1'b1;
        seen_nxt[idx] = 1'b0;
      end
    end else if (fire && multi_low) begin
      err_nxt = 1'b1;
    end
  end

  // State register: input sampling, dwell counter, slots, frame output.
  always_ff @(posedge clkin) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees the pre-edge values of the others.
    if (btnR) begin
      // The idle bus (all segments and anodes off) is the reset sample, so
      // a blank display right after reset is not taken as a change.
      s_an        <= 4'hF;
      s_seg       <= 7'h7F;
      p_an        <= 4'hF;
      p_seg       <= 7'h7F;
      cnt         <= '0;
      captured    <= 1'b0;
      digit_seen  <= 4'b0000;
      value       <= 16'h0000;
      value_valid <= 1'b0;
      bad_seg     <= 1'b0;
      an_err      <= 1'b0;
      for (int i = 0; i < 4; i++) slot[i] <= 4'h0;
    end else begin
      s_an       <= an;
      s_seg      <= seg;
      p_an       <= s_an;
      p_seg      <= s_seg;
      cnt        <= cnt_nxt;
      captured   <= captured_nxt;
      digit_seen <= seen_nxt;
      bad_seg    <= bad_nxt;
      an_err     <= err_nxt;
      if (slot_we) slot[idx] <= dec[3:0];
      value_valid <= frame_done;
      if (frame_done) value <= {slot[3], slot[2], slot[1], slot[0]};
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE=4: drives hand-picked
// an/seg dwells and compares outputs and pulse counts to fixed values.
module tb_seg_scan_decoder;

  logic        clkin = 1'b0;
  logic        btnR  = 1'b1;
  logic [3:0]  an    = 4'hF;
  logic [6:0]  seg   = 7'h7F;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit_seen;
  logic        bad_seg;
  logic        an_err;

  int n_checks = 0;
  int n_bad    = 0;
  int vv_cnt   = 0;
  int bad_cnt  = 0;
  int err_cnt  = 0;
  int vv0, bad0, err0;

  seg_scan_decoder #(.SETTLE(4), .CW(8)) dut (
    .clkin       (clkin),
    .btnR        (btnR),
    .an          (an),
    .seg         (seg),
    .value       (value),
    .value_valid (value_valid),
    .digit_seen  (digit_seen),
    .bad_seg     (bad_seg),
    .an_err      (an_err)
  );

  always #5 clkin = ~clkin;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clkin) begin
    if (value_valid) vv_cnt++;
    if (bad_seg)     bad_cnt++;
    if (an_err)      err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one pattern for n cycles, then move to mid-cycle for checking.
  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    @(posedge clkin); #1;
    an  = a;
    seg = s;
    repeat (n) @(posedge clkin);
    @(negedge clkin);
  endtask

  task automatic mark();
    vv0  = vv_cnt;
    bad0 = bad_cnt;
    err0 = err_cnt;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clkin);
    #1 btnR = 1'b0;
    @(negedge clkin);
    check("rst_value", value, 16'h0000);
    check("rst_valid", value_valid, 0);
    check("rst_seen", digit_seen, 4'b0000);
    check("rst_bad", bad_seg, 0);
    check("rst_err", an_err, 0);

    // Basic scan 0x9034
    mark();
    hold(4'hE, 7'h19, 20);
    check("scan_seen0", digit_seen, 4'b0001);
    hold(4'hD, 7'h30, 20);
    hold(4'hB, 7'h40, 20);
    check("scan_seen2", digit_seen, 4'b0111);
    hold(4'h7, 7'h10, 20);
    check("scan_value", value, 16'h9034);
    check("scan_vv", vv_cnt - vv0, 1);
    check("scan_seen_clr", digit_seen, 4'b0000);

    // Short glitch on slot 0 is ignored; the settled "1" is kept
    mark();
    hold(4'hE, 7'h19, 2);
    hold(4'hE, 7'h79, 10);
    check("glitch_seen", digit_seen, 4'b0001);
    check("glitch_bad", bad_cnt - bad0, 0);
    hold(4'hD, 7'h30, 20);
    hold(4'hB, 7'h40, 20);
    hold(4'h7, 7'h10, 20);
    check("glitch_value", value, 16'h9031);
    check("glitch_vv", vv_cnt - vv0, 1);

    // Illegal glyph on digit 1
    mark();
    hold(4'hD, 7'h30, 10);
    check("badg_pre_seen", digit_seen, 4'b0010);
    hold(4'hD, 7'h7F, 10);
    check("badg_pulse", bad_cnt - bad0, 1);
    check("badg_seen", digit_seen, 4'b0000);
    check("badg_value", value, 16'h9031);

    // Two anodes low, then a long blank
    mark();
    hold(4'hE, 7'h40, 10);
    hold(4'hC, 7'h40, 10);
    check("anerr_pulse", err_cnt - err0, 1);
    check("anerr_seen", digit_seen, 4'b0001);
    mark();
    hold(4'hF, 7'h7F, 50);
    check("blank_vv", vv_cnt - vv0, 0);
    check("blank_bad", bad_cnt - bad0, 0);
    check("blank_err", err_cnt - err0, 0);

    // Mid-frame reset discards the partial frame
    hold(4'hE, 7'h00, 10);
    hold(4'hD, 7'h00, 10);
    hold(4'hB, 7'h00, 10);
    check("prerst_seen", digit_seen, 4'b0111);
    @(posedge clkin); #1;
    an = 4'hF; seg = 7'h7F; btnR = 1'b1;
    @(posedge clkin); #1;
    btnR = 1'b0;
    @(negedge clkin);
    check("midrst_seen", digit_seen, 4'b0000);
    check("midrst_value", value, 16'h0000);
    mark();
    hold(4'h7, 7'h08, 20);
    hold(4'hB, 7'h03, 20);
    hold(4'hD, 7'h46, 20);
    hold(4'hE, 7'h21, 20);
    check("abcd_value", value, 16'hABCD);
    check("abcd_vv", vv_cnt - vv0, 1);

    // Two back-to-back all-zero frames
    mark();
    for (int f = 0; f < 2; f++) begin
      hold(4'hE, 7'h40, 12);
      hold(4'hD, 7'h40, 12);
      hold(4'hB, 7'h40, 12);
      hold(4'h7, 7'h40, 12);
    end
    check("zero_value", value, 16'h0000);
    check("zero_vv", vv_cnt - vv0, 2);

    // Long dwell on one digit captures once and raises nothing else
    mark();
    hold(4'hE, 7'h79, 100);
    check("dwell_seen", digit_seen, 4'b0001);
    check("dwell_vv", vv_cnt - vv0, 0);
    check("dwell_bad", bad_cnt - bad0, 0);
    check("dwell_err", err_cnt - err0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
